// File: rtl/arcade_input_pkg.sv
// Shared constants, rotation type and decode helpers for the arcade input mapper.
package arcade_input_pkg;

    localparam logic [2:0] CSJ_R     = 3'd0;
    localparam logic [2:0] CSJ_L     = 3'd1;
    localparam logic [2:0] CSJ_D     = 3'd2;
    localparam logic [2:0] CSJ_U     = 3'd3;
    localparam logic [2:0] CSJ_FIRE  = 3'd4;
    localparam logic [2:0] CSJ_START = 3'd5;
    localparam logic [2:0] CSJ_COIN  = 3'd6;

    localparam int JOY_R     = 0;
    localparam int JOY_L     = 1;
    localparam int JOY_D     = 2;
    localparam int JOY_U     = 3;
    localparam int JOY_FIRE  = 4;
    localparam int JOY_START = 5;
    localparam int JOY_COIN  = 6;

    // Cursor keys match with or without the E0 extended prefix
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam logic [8:0] KEY_FIRE_1  = 9'h029;
    localparam logic [8:0] KEY_FIRE_2  = 9'h014;
    localparam logic [8:0] KEY_START_1 = 9'h005;
    localparam logic [8:0] KEY_START_2 = 9'h016;
    localparam logic [8:0] KEY_COIN    = 9'h02E;

    localparam logic [8:0] KEY_P1_UP      = 9'h02D;
    localparam logic [8:0] KEY_P1_DOWN    = 9'h02B;
    localparam logic [8:0] KEY_P1_LEFT    = 9'h023;
    localparam logic [8:0] KEY_P1_RIGHT   = 9'h034;
    localparam logic [8:0] KEY_P1_FIRE    = 9'h01C;
    localparam logic [8:0] KEY_P1_START_1 = 9'h006;
    localparam logic [8:0] KEY_P1_START_2 = 9'h01E;
    localparam logic [8:0] KEY_P1_COIN    = 9'h036;

    typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_e;

    typedef struct packed {
        logic       hit0;
        logic       hit1;
        logic [2:0] btn;
    } key_hit_t;

    function automatic logic [3:0] rotate_dirs(input rot_e rot, input logic [3:0] udlr);
        logic [3:0] r;
        r = udlr;
        case (rot)
            ROT_90:  r = {udlr[1], udlr[0], udlr[2], udlr[3]};
            ROT_180: r = {udlr[2], udlr[3], udlr[0], udlr[1]};
            ROT_270: r = {udlr[0], udlr[1], udlr[3], udlr[2]};
            default: r = udlr;
        endcase
        return r;
    endfunction

    function automatic key_hit_t key_decode(input logic [8:0] c);
        key_hit_t h;
        h = '0;
        unique case (1'b1)
            (c[7:0] == KEY_UP):    h = {1'b1, 1'b0, CSJ_U};
            (c[7:0] == KEY_DOWN):  h = {1'b1, 1'b0, CSJ_D};
            (c[7:0] == KEY_LEFT):  h = {1'b1, 1'b0, CSJ_L};
            (c[7:0] == KEY_RIGHT): h = {1'b1, 1'b0, CSJ_R};
            (c == KEY_FIRE_1),
            (c == KEY_FIRE_2):     h = {1'b1, 1'b0, CSJ_FIRE};
            (c == KEY_START_1),
            (c == KEY_START_2):    h = {1'b1, 1'b0, CSJ_START};
            (c == KEY_COIN):       h = {1'b1, 1'b0, CSJ_COIN};
            (c == KEY_P1_UP):      h = {1'b0, 1'b1, CSJ_U};
            (c == KEY_P1_DOWN):    h = {1'b0, 1'b1, CSJ_D};
            (c == KEY_P1_LEFT):    h = {1'b0, 1'b1, CSJ_L};
            (c == KEY_P1_RIGHT):   h = {1'b0, 1'b1, CSJ_R};
            (c == KEY_P1_FIRE):    h = {1'b0, 1'b1, CSJ_FIRE};
            (c == KEY_P1_START_1),
            (c == KEY_P1_START_2): h = {1'b0, 1'b1, CSJ_START};
            (c == KEY_P1_COIN):    h = {1'b0, 1'b1, CSJ_COIN};
            default:               h = '0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/arcade_coin_pulse.sv
// Coin pulse stretcher: a rising source edge while idle yields COIN_PULSE high cycles.
module arcade_coin_pulse #(
    parameter int unsigned COIN_PULSE = 50000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic src,
    output logic pulse
);

    localparam int CW = $clog2(COIN_PULSE + 1);

    logic [CW-1:0] r_cnt;
    logic          r_src_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_src_d <= 1'b0;
        end else begin
            r_src_d <= src;
            if (src && !r_src_d && (r_cnt == '0)) begin
                r_cnt <= CW'(COIN_PULSE);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign pulse = (r_cnt != '0);

endmodule

// File: rtl/arcade_input_mapper.sv
// PS/2 + joystick merge, rotation remap and coin stretch into per-player CSJUDLR.
// Optional macro AUTOFIRE_EN gates fire with a free-running square wave.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int          NUM_PLAYERS  = 2,
    parameter int unsigned COIN_PULSE   = 50000,
    parameter int unsigned AUTOFIRE_DIV = 200000
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [10:0]              ps2_key,
    input  logic [16*NUM_PLAYERS-1:0] joystick,
    input  logic [1:0]               rotate,
    input  logic                     auto_coin,
    input  logic [NUM_PLAYERS-1:0]   autofire,
    output logic [7*NUM_PLAYERS-1:0] csjudlr,
    output logic                     key_activity
);

    logic            r_tog;
    logic            r_armed;
    logic            r_act;
    logic [1:0][6:0] r_held;
    logic            w_event;
    key_hit_t        w_hit;

    // r_armed keeps the first post-reset cycle from decoding a stale toggle
    assign w_event = r_armed & (ps2_key[10] ^ r_tog);
    assign w_hit   = key_decode(ps2_key[8:0]);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_tog   <= 1'b0;
            r_armed <= 1'b0;
            r_act   <= 1'b0;
            r_held  <= '0;
        end else begin
            r_tog   <= ps2_key[10];
            r_armed <= 1'b1;
            r_act   <= w_event;
            if (w_event && w_hit.hit0) r_held[0][w_hit.btn] <= ps2_key[9];
            if (w_event && w_hit.hit1) r_held[1][w_hit.btn] <= ps2_key[9];
        end
    end

    assign key_activity = r_act;

`ifdef AUTOFIRE_EN
    localparam int AFW = $clog2(AUTOFIRE_DIV + 1);

    logic [AFW-1:0] r_af_cnt;
    logic           r_af;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_af_cnt <= '0;
            r_af     <= 1'b1;
        end else if (r_af_cnt == AFW'(AUTOFIRE_DIV - 1)) begin
            r_af_cnt <= '0;
            r_af     <= ~r_af;
        end else begin
            r_af_cnt <= r_af_cnt + 1'b1;
        end
    end
`else
    logic w_unused_af;
    assign w_unused_af = ^autofire;
`endif

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
        logic [6:0] w_key;
        logic [6:0] w_raw;
        logic [3:0] w_dirs;
        logic       w_fire;
        logic       w_src;
        logic       w_coin;
        logic       w_unused;
        logic [5:0] r_out;

        if (p < 2) begin : g_key
            assign w_key = r_held[p];
        end else begin : g_nokey
            assign w_key = '0;
        end

        assign w_unused = ^joystick[16*p+7 +: 9];
        assign w_raw    = w_key | joystick[16*p +: 7];
        assign w_dirs   = rotate_dirs(rot_e'(rotate), w_raw[3:0]);
        assign w_src    = w_raw[CSJ_COIN] | (auto_coin & w_raw[CSJ_START]);

`ifdef AUTOFIRE_EN
        assign w_fire = w_raw[CSJ_FIRE] & (r_af | ~autofire[p]);
`else
        assign w_fire = w_raw[CSJ_FIRE];
`endif

        arcade_coin_pulse #(
            .COIN_PULSE(COIN_PULSE)
        ) u_coin (
            .clk_sys(clk_sys),
            .reset_n(reset_n),
            .src    (w_src),
            .pulse  (w_coin)
        );

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_out <= '0;
            end else begin
                r_out <= {w_raw[CSJ_START], w_fire, w_dirs};
            end
        end

        assign csjudlr[7*p +: 7] = {w_coin, r_out};
    end

endmodule
